// File: rtl/oh_sign_restore_pkg.sv
// -----------------------------------------------------------------------------
// oh_sign_restore_pkg
// Shared types and constant helpers for the slice-serial sign-restore block.
//   state_t    : FSM encoding (IDLE, BUSY, DONE)
//   cnt_width  : width of the slice counter, clog2(N/W) with a floor of 1
//   sat_value  : saturation constant for an n-bit signed range
//                (neg=0 -> 0111..1, neg=1 -> 1000..0), returned MAX_N wide
// -----------------------------------------------------------------------------
package oh_sign_restore_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int MAX_N = 256;

   function automatic int cnt_width(input int n, input int w);
      int slices;
      slices = n / w;
      return (slices > 2) ? $clog2(slices) : 1;
   endfunction

   function automatic logic [MAX_N-1:0] sat_value(input int n, input logic neg);
      logic [MAX_N-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i == n - 1) begin
            v[i] = neg;
         end else if (i < n - 1) begin
            v[i] = ~neg;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/oh_sign_slice.sv
// -----------------------------------------------------------------------------
// oh_sign_slice
// Combinational W-bit slice of a two's-complement negate: optionally inverts
// the magnitude slice and adds the incoming carry.
//   mag       : magnitude slice
//   invert    : 1 = negative operand, invert the slice
//   carry_in  : carry from the previous (less significant) slice
//   slice     : result slice
//   carry_out : carry into the next slice
// -----------------------------------------------------------------------------
module oh_sign_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] mag,
   input  logic         invert,
   input  logic         carry_in,
   output logic [W-1:0] slice,
   output logic         carry_out
);

   logic [W-1:0] opnd_s;
   logic [W:0]   sum_s;

   // Conditional invert followed by carry-in increment.
   always_comb begin
      if (invert) begin
         opnd_s = ~mag;
      end else begin
         opnd_s = mag;
      end
      sum_s     = {1'b0, opnd_s} + {{W{1'b0}}, carry_in};
      slice     = sum_s[W-1:0];
      carry_out = sum_s[W];
   end

endmodule

// File: rtl/oh_sign_restore.sv
// -----------------------------------------------------------------------------
// oh_sign_restore
// Rebuilds a signed two's-complement value from magnitude + sign, W bits per
// cycle with the carry rippled across cycles. Result after N/W cycles.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_mag, in_sign)
//   out_valid/out_ready  : result handshake (out, overflow)
//   overflow             : result does not fit the N-bit signed range
// Optional build macro OH_SIGN_RESTORE_SAT_EN: overflowing results are
// presented saturated (0111..1 / 1000..0) instead of wrapped.
// -----------------------------------------------------------------------------
module oh_sign_restore
   import oh_sign_restore_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_mag,
   input  logic         in_sign,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         overflow
);

   localparam int              SLICES = N / W;
   localparam int              CW     = cnt_width(N, W);
   localparam logic [CW-1:0]   LAST   = CW'(SLICES - 1);
   localparam logic [CW-1:0]   ONE    = CW'(1);

`ifdef OH_SIGN_RESTORE_SAT_EN
   localparam logic [MAX_N-1:0] SAT_POS_FULL = sat_value(N, 1'b0);
   localparam logic [MAX_N-1:0] SAT_NEG_FULL = sat_value(N, 1'b1);
   localparam logic [N-1:0]     SAT_POS      = SAT_POS_FULL[N-1:0];
   localparam logic [N-1:0]     SAT_NEG      = SAT_NEG_FULL[N-1:0];
`endif

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r;
   logic            carry_r;
   logic            sign_r;
   logic            ovf_r;
   logic [N-1:0]    opnd_r;
   logic [N-W-1:0]  res_r;
   logic [N-1:0]    out_r;
   logic            overflow_r;

   logic            load_s;
   logic            ovf_s;
   logic [W-1:0]    slice_s;
   logic            carry_s;
   logic [N-1:0]    wrap_s;
   logic [N-1:0]    final_s;

   oh_sign_slice #(.W(W)) u_slice (
      .mag       (opnd_r[W-1:0]),
      .invert    (sign_r),
      .carry_in  (carry_r),
      .slice     (slice_s),
      .carry_out (carry_s)
   );

   assign load_s   = in_valid & in_ready;
   assign wrap_s   = {slice_s, res_r};
   assign out      = out_r;
   assign overflow = overflow_r;

   // Overflow of the incoming operand; only 2^(N-1) is legal with the top bit set when negative.
   always_comb begin
      if (in_sign) begin
         ovf_s = in_mag[N-1] & (|in_mag[N-2:0]);
      end else begin
         ovf_s = in_mag[N-1];
      end
   end

   // Value presented once the last slice is done.
   always_comb begin
`ifdef OH_SIGN_RESTORE_SAT_EN
      if (ovf_r) begin
         final_s = sign_r ? SAT_NEG : SAT_POS;
      end else begin
         final_s = wrap_s;
      end
`else
      final_s = wrap_s;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) state_s = BUSY;
            else          state_s = IDLE;
         end
         BUSY: begin
            if (cnt_r == LAST) state_s = DONE;
            else               state_s = BUSY;
         end
         DONE: begin
            if (out_ready) state_s = in_valid ? BUSY : IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM handshake outputs; DONE passes out_ready through for back-to-back accepts.
   always_comb begin
      case (state_r)
         IDLE: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         BUSY: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
         DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Operand capture, per-slice shift/carry ripple and result hand-off.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r      <= '0;
         carry_r    <= 1'b0;
         sign_r     <= 1'b0;
         ovf_r      <= 1'b0;
         opnd_r     <= '0;
         res_r      <= '0;
         out_r      <= '0;
         overflow_r <= 1'b0;
      end else if (load_s) begin
         cnt_r      <= '0;
         carry_r    <= in_sign;
         sign_r     <= in_sign;
         ovf_r      <= ovf_s;
         opnd_r     <= in_mag;
      end else if (state_r == BUSY) begin
         // Result enters from the top so the LSB slice ends up at bit 0.
         opnd_r  <= {{W{1'b0}}, opnd_r[N-1:W]};
         res_r   <= wrap_s[N-1:W];
         carry_r <= carry_s;
         if (cnt_r == LAST) begin
            out_r      <= final_s;
            overflow_r <= ovf_r;
         end else begin
            cnt_r <= cnt_r + ONE;
         end
      end else begin
         out_r <= out_r;
      end
   end

endmodule
